// File: rtl/hazard_controller.sv
// Hazard/sequencing controller for a 5-stage RISC-V pipeline: forwarding, load-use stalls,
// control flushes and a data-memory wait-state FSM. Define HAZARD_PERF_CNT_EN for perf counters.
module hazard_controller #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       ResultSrcE0,
    input  logic [1:0] ResultSrcM,
    input  logic       MemWriteM,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic [1:0] PCSrcE,
    input  logic       DMemReady,
    output logic       DMemReq,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       StallW,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MemErr
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] LwStallCnt,
    output logic [31:0] MemStallCnt,
    output logic [31:0] FlushCnt
`endif
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mem_err;

    logic mem_op;
    logic abort;
    logic mem_stall;
    logic lw_stall;
    logic redirect;

    assign mem_op    = (ResultSrcM == 2'b01) | MemWriteM;
    assign abort     = (state == WAIT) & ~DMemReady & (cnt == CNT_W'(MEM_TIMEOUT));
    assign mem_stall = mem_op & ~DMemReady & ~abort;
    assign lw_stall  = ResultSrcE0 & (RdE != 5'd0) & ((Rs1D == RdE) | (Rs2D == RdE)) & ~mem_stall;
    assign redirect  = PCSrcE != 2'b00;

    // A matching M-stage load/link is not forwarded from M; the W check still applies.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                           input logic [4:0] rd_w, input logic [1:0] src_m,
                                           input logic we_m, input logic we_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0) begin
            if (we_m && rd_m == rs && src_m == 2'b11)      sel = 2'b11;
            else if (we_m && rd_m == rs && src_m == 2'b00) sel = 2'b10;
            else if (we_w && rd_w == rs)                   sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        DMemReq   = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        StallW    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        MemErr    = 1'b0;
        if (!rst) begin
            DMemReq   = (state == WAIT) ? 1'b1 : mem_op;
            StallF    = lw_stall | mem_stall;
            StallD    = lw_stall | mem_stall;
            StallE    = mem_stall;
            StallM    = mem_stall;
            StallW    = mem_stall;
            FlushD    = redirect & ~mem_stall;
            FlushE    = (lw_stall | redirect) & ~mem_stall;
            ForwardAE = fwd_sel(Rs1E, RdM, RdW, ResultSrcM, RegWriteM, RegWriteW);
            ForwardBE = fwd_sel(Rs2E, RdM, RdW, ResultSrcM, RegWriteM, RegWriteW);
            MemErr    = mem_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            mem_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op && !DMemReady) begin
                        state <= WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (DMemReady) begin
                        state <= IDLE;
                    end else if (abort) begin
                        state   <= IDLE;
                        mem_err <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            LwStallCnt  <= '0;
            MemStallCnt <= '0;
            FlushCnt    <= '0;
        end else begin
            if (lw_stall && LwStallCnt != '1)
                LwStallCnt <= LwStallCnt + 32'd1;
            if (mem_stall && MemStallCnt != '1)
                MemStallCnt <= MemStallCnt + 32'd1;
            if (redirect && !mem_stall && FlushCnt != '1)
                FlushCnt <= FlushCnt + 32'd1;
        end
    end
`endif

endmodule
